rotary_position_tracker: RTL and testbench

- Downstream consumer of the rotary encoder's one-cycle step pulses (right/left).
- Turns them into a bounded, optionally wrapping position value with speed-based acceleration.
- Publishes each position change as a valid/ready event to the menu/UI logic.
- Also provides a synchronous preset load.

---
 rtl/rotary_position_tracker.sv | 188 ++++++++++++++++++
 tb/tb_rotary_position_tracker.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotary_position_tracker.sv
// Turns encoder step pulses into a bounded, optionally wrapping position with
// speed-based acceleration, and publishes every position change as a valid/ready event.
module rotary_position_tracker #(
  parameter int WIDTH       = 8,
  parameter int MIN_VAL     = 0,
  parameter int MAX_VAL     = 99,
  parameter int INIT_VAL    = 0,
  parameter int WRAP        = 1,
  parameter int FAST_WINDOW = 2500000,
  parameter int FAST_THRESH = 3,
  parameter int FAST_STEP   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             step_right,
  input  logic             step_left,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] position,
  output logic             changed,
  output logic             accel,
  output logic             evt_valid,
  output logic             evt_dir,
  output logic [WIDTH-1:0] evt_pos,
  input  logic             evt_ready,
  output logic             evt_overrun
);

  localparam int GW = $clog2(FAST_WINDOW + 1);
  localparam int SW = $clog2(FAST_THRESH + 1);
  localparam logic [GW-1:0]    GAP_MAX    = GW'(FAST_WINDOW);
  localparam logic [SW-1:0]    STREAK_MAX = SW'(FAST_THRESH);
  localparam logic [WIDTH:0]   MIN_X      = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_X      = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   ONE_X      = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   FSTEP_X    = (WIDTH+1)'(FAST_STEP);
  localparam logic [WIDTH-1:0] POS_INIT   = WIDTH'(INIT_VAL);

  typedef enum logic {SLOW = 1'b0, FAST = 1'b1} state_t;

  state_t state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d, next_pos;
  logic [WIDTH-1:0] evt_pos_q, evt_pos_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [SW-1:0]    streak_q, streak_d;
  logic             changed_q, changed_d;
  logic             last_dir_q, last_dir_d;
  logic             evt_valid_q, evt_valid_d;
  logic             evt_dir_q, evt_dir_d;
  logic             evt_overrun_q, evt_overrun_d;
  logic             post, post_dir;
  logic             step_take, same_dir, cont;
  logic [WIDTH:0]   step_size;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] vx;
    vx = {1'b0, v};
    if (vx < MIN_X) vx = MIN_X;
    else if (vx > MAX_X) vx = MAX_X;
    return vx[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] move_right(input logic [WIDTH-1:0] pos,
                                                  input logic [WIDTH:0] s);
    logic [WIDTH:0] sum;
    sum = {1'b0, pos} + s;
    if (sum > MAX_X) begin
      if (WRAP != 0) sum = MIN_X + (sum - MAX_X - ONE_X);
      else           sum = MAX_X;
    end
    return sum[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] move_left(input logic [WIDTH-1:0] pos,
                                                 input logic [WIDTH:0] s);
    logic [WIDTH:0] res;
    if ({1'b0, pos} < MIN_X + s) begin
      if (WRAP != 0) res = MAX_X - (MIN_X + s - {1'b0, pos} - ONE_X);
      else           res = MIN_X;
    end else begin
      res = {1'b0, pos} - s;
    end
    return res[WIDTH-1:0];
  endfunction

  // A load in the same cycle swallows the step entirely.
  assign step_take = enable && (step_right ^ step_left) && !load;
  assign same_dir  = (step_right == last_dir_q);
  assign cont      = same_dir && (gap_q < GAP_MAX);
  assign step_size = ((state_q == FAST) && cont) ? FSTEP_X : ONE_X;

  always_comb begin
    pos_d         = pos_q;
    changed_d     = 1'b0;
    last_dir_d    = last_dir_q;
    gap_d         = gap_q;
    streak_d      = streak_q;
    evt_valid_d   = evt_valid_q;
    evt_dir_d     = evt_dir_q;
    evt_pos_d     = evt_pos_q;
    evt_overrun_d = evt_overrun_q;
    next_pos      = pos_q;
    post          = 1'b0;
    post_dir      = last_dir_q;

    if (step_take)            gap_d = '0;
    else if (gap_q < GAP_MAX) gap_d = gap_q + GW'(1);

    if (load || !enable) streak_d = '0;
    else if (step_take)  streak_d = !cont ? SW'(1) :
                                    (streak_q < STREAK_MAX) ? streak_q + SW'(1) : STREAK_MAX;

    if (load) begin
      next_pos = clamp_load(load_val);
    end else if (step_take) begin
      next_pos   = step_right ? move_right(pos_q, step_size) : move_left(pos_q, step_size);
      last_dir_d = step_right;
      post_dir   = step_right;
    end

    if (next_pos != pos_q) begin
      pos_d     = next_pos;
      changed_d = 1'b1;
      post      = 1'b1;
    end

    // A fresh event in the consume cycle keeps evt_valid high with the new payload.
    if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;
    if (post) begin
      if (evt_valid_q && !evt_ready) evt_overrun_d = 1'b1;
      evt_valid_d = 1'b1;
      evt_dir_d   = post_dir;
      evt_pos_d   = next_pos;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable || load) begin
      state_d = SLOW;
    end else begin
      case (state_q)
        SLOW:    if (step_take && (streak_d == STREAK_MAX)) state_d = FAST;
        FAST:    if ((gap_q >= GAP_MAX) || (step_take && !same_dir)) state_d = SLOW;
        default: state_d = SLOW;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= SLOW;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q         <= POS_INIT;
      changed_q     <= 1'b0;
      last_dir_q    <= 1'b0;
      gap_q         <= '0;
      streak_q      <= '0;
      evt_valid_q   <= 1'b0;
      evt_dir_q     <= 1'b0;
      evt_pos_q     <= '0;
      evt_overrun_q <= 1'b0;
    end else begin
      pos_q         <= pos_d;
      changed_q     <= changed_d;
      last_dir_q    <= last_dir_d;
      gap_q         <= gap_d;
      streak_q      <= streak_d;
      evt_valid_q   <= evt_valid_d;
      evt_dir_q     <= evt_dir_d;
      evt_pos_q     <= evt_pos_d;
      evt_overrun_q <= evt_overrun_d;
    end
  end

  assign position    = pos_q;
  assign changed     = changed_q;
  assign accel       = (state_q == FAST);
  assign evt_valid   = evt_valid_q;
  assign evt_dir     = evt_dir_q;
  assign evt_pos     = evt_pos_q;
  assign evt_overrun = evt_overrun_q;

endmodule

// File: tb/tb_rotary_position_tracker.sv
// Bench for rotary_position_tracker: a wrapping and a saturating instance share stimulus
// and are checked every cycle against an arithmetic model plus literal expectations.
module tb_rotary_position_tracker;

  localparam int W      = 8;
  localparam int MINV   = 0;
  localparam int MAXV   = 99;
  localparam int WIN    = 2000;
  localparam int THRESH = 3;
  localparam int FSTEP  = 5;

  logic clk = 1'b0;
  logic rst_n, enable, step_right, step_left, load, evt_ready;
  logic [W-1:0] load_val;

  logic [W-1:0] pos_w, epos_w, pos_s, epos_s;
  logic chg_w, acc_w, ev_w, edir_w, ovr_w;
  logic chg_s, acc_s, ev_s, edir_s, ovr_s;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rotary_position_tracker #(.WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .INIT_VAL(0), .WRAP(1),
    .FAST_WINDOW(WIN), .FAST_THRESH(THRESH), .FAST_STEP(FSTEP)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .step_right(step_right), .step_left(step_left),
    .load(load), .load_val(load_val), .position(pos_w), .changed(chg_w), .accel(acc_w),
    .evt_valid(ev_w), .evt_dir(edir_w), .evt_pos(epos_w), .evt_ready(evt_ready),
    .evt_overrun(ovr_w));

  rotary_position_tracker #(.WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .INIT_VAL(0), .WRAP(0),
    .FAST_WINDOW(WIN), .FAST_THRESH(THRESH), .FAST_STEP(FSTEP)) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .step_right(step_right), .step_left(step_left),
    .load(load), .load_val(load_val), .position(pos_s), .changed(chg_s), .accel(acc_s),
    .evt_valid(ev_s), .evt_dir(edir_s), .evt_pos(epos_s), .evt_ready(evt_ready),
    .evt_overrun(ovr_s));

  typedef struct {
    int pos;
    bit last_dir;
    int streak;
    int since;
    bit fast;
    bit chg;
    bit ev;
    bit edir;
    int epos;
    bit ovr;
  } model_t;

  model_t mdl [2];

  function automatic model_t model_reset();
    model_t m;
    m.pos = 0; m.last_dir = 0; m.streak = 0; m.since = 0; m.fast = 0;
    m.chg = 0; m.ev = 0; m.edir = 0; m.epos = 0; m.ovr = 0;
    return m;
  endfunction

  function automatic model_t model_next(model_t m, bit wrap, bit rn, bit en, bit r, bit l,
                                        bit ld, int lv, bit rdy);
    model_t n;
    int range, v, s, np;
    bit moved, pdir, cont;
    if (!rn) return model_reset();
    n = m;
    n.chg = 0;
    range = MAXV - MINV + 1;
    moved = 0;
    pdir  = m.last_dir;
    np    = m.pos;
    if (m.ev && rdy) n.ev = 0;
    if (ld) begin
      v = (lv < MINV) ? MINV : (lv > MAXV) ? MAXV : lv;
      n.streak = 0;
      n.fast   = 0;
      n.since  = (m.since + 1 > WIN) ? WIN : m.since + 1;
      np = v;
    end else if (en && (r != l)) begin
      cont = (r == m.last_dir) && (m.since < WIN);
      n.streak = cont ? ((m.streak + 1 > THRESH) ? THRESH : m.streak + 1) : 1;
      s = (m.fast && cont) ? FSTEP : 1;
      if (r) np = wrap ? MINV + ((m.pos - MINV + s) % range)
                       : ((m.pos + s > MAXV) ? MAXV : m.pos + s);
      else   np = wrap ? MINV + ((m.pos - MINV - s + range) % range)
                       : ((m.pos - s < MINV) ? MINV : m.pos - s);
      n.fast = m.fast ? cont : (n.streak == THRESH);
      n.last_dir = r;
      pdir    = r;
      n.since = 0;
    end else begin
      n.since = (m.since + 1 > WIN) ? WIN : m.since + 1;
      if (!en) begin
        n.streak = 0;
        n.fast   = 0;
      end else if (m.since >= WIN) begin
        n.fast = 0;
      end
    end
    moved = (np != m.pos);
    if (moved) begin
      n.pos = np;
      n.chg = 1;
      if (m.ev && !rdy) n.ovr = 1;
      n.ev   = 1;
      n.edir = pdir;
      n.epos = np;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    mdl[0] <= model_next(mdl[0], 1'b1, rst_n, enable, step_right, step_left, load,
                         int'(load_val), evt_ready);
    mdl[1] <= model_next(mdl[1], 1'b0, rst_n, enable, step_right, step_left, load,
                         int'(load_val), evt_ready);
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [20:0] act, exp;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        if (k == 0) act = {pos_w, chg_w, acc_w, ev_w, edir_w, epos_w, ovr_w};
        else        act = {pos_s, chg_s, acc_s, ev_s, edir_s, epos_s, ovr_s};
        exp = {W'(mdl[k].pos), mdl[k].chg, mdl[k].fast, mdl[k].ev, mdl[k].edir,
               W'(mdl[k].epos), mdl[k].ovr};
        n_vec++;
        if (act !== exp) begin
          n_bad++;
          $display("FAIL model_cmp inst%0d t=%0t: got %h expected %h", k, $time, act, exp);
        end
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit r, input bit l);
    step_right = r;
    step_left  = l;
    tick();
    step_right = 0;
    step_left  = 0;
  endtask

  task automatic do_load(input int v, input bit r);
    load       = 1;
    load_val   = W'(v);
    step_right = r;
    tick();
    load       = 0;
    step_right = 0;
  endtask

  initial begin
    rst_n = 0; enable = 0; step_right = 0; step_left = 0; load = 0; load_val = '0;
    evt_ready = 0;
    tick();
    chk_en = 1'b1;
    tick();
    check_lit("reset_pos", int'(pos_w), 0);
    check_lit("reset_evt_valid", int'(ev_w), 0);
    check_lit("reset_accel", int'(acc_w), 0);
    check_lit("reset_overrun", int'(ovr_w), 0);
    rst_n = 1; enable = 1; evt_ready = 1;

    // Slow steps, spaced beyond the window.
    for (int i = 1; i <= 3; i++) begin
      repeat (WIN + 1000) tick();
      pulse(1, 0);
      check_lit("slow_pos", int'(pos_w), i);
      check_lit("slow_model_pos", mdl[0].pos, i);
      check_lit("slow_changed", int'(chg_w), 1);
      check_lit("slow_dir", int'(edir_w), 1);
      check_lit("slow_accel", int'(acc_w), 0);
    end

    // Acceleration: 1,2,3,8,13 then timeout, then 14.
    do_load(0, 0);
    repeat (WIN + 100) tick();
    for (int i = 0; i < 5; i++) begin
      int exp_pos [5] = '{1, 2, 3, 8, 13};
      pulse(1, 0);
      check_lit("accel_pos", int'(pos_w), exp_pos[i]);
      check_lit("accel_model_pos", mdl[0].pos, exp_pos[i]);
      check_lit("accel_flag", int'(acc_w), (i >= 2) ? 1 : 0);
      repeat (999) tick();
    end
    repeat (WIN + 100) tick();
    check_lit("accel_timeout", int'(acc_w), 0);
    pulse(1, 0);
    check_lit("after_timeout_pos", int'(pos_w), 14);

    // Range ends: wrap vs saturate.
    do_load(99, 0);
    tick();
    pulse(1, 0);
    check_lit("wrap_right", int'(pos_w), 0);
    check_lit("sat_right", int'(pos_s), 99);
    check_lit("sat_right_changed", int'(chg_s), 0);
    check_lit("sat_right_evt", int'(ev_s), 0);
    do_load(0, 0);
    tick();
    pulse(0, 1);
    check_lit("wrap_left", int'(pos_w), 99);
    check_lit("wrap_left_model", mdl[0].pos, 99);
    check_lit("sat_left", int'(pos_s), 0);
    check_lit("sat_left_changed", int'(chg_s), 0);

    // Handshake with a stalled consumer.
    do_load(3, 0);
    repeat (2) tick();
    evt_ready = 0;
    pulse(1, 0);
    repeat (3) tick();
    pulse(1, 0);
    check_lit("hs_evt_pos", int'(epos_w), 5);
    check_lit("hs_overrun", int'(ovr_w), 1);
    check_lit("hs_valid", int'(ev_w), 1);
    evt_ready = 1;
    tick();
    evt_ready = 0;
    check_lit("hs_consumed", int'(ev_w), 0);
    evt_ready = 1;

    // Both directions at once, then a load beating a step while accelerated.
    pulse(1, 1);
    check_lit("both_pos", int'(pos_w), 5);
    check_lit("both_changed", int'(chg_w), 0);
    tick();
    pulse(1, 0);
    check_lit("re_accel_pos", int'(pos_w), 6);
    check_lit("re_accel_flag", int'(acc_w), 1);
    repeat (5) tick();
    pulse(1, 0);
    check_lit("fast_pos", int'(pos_w), 11);
    do_load(200, 1);
    check_lit("load_clamp", int'(pos_w), 99);
    check_lit("load_clamp_sat", int'(pos_s), 99);
    check_lit("load_accel", int'(acc_w), 0);

    // Disabled: steps ignored, load still works.
    enable = 0;
    pulse(1, 0);
    pulse(0, 1);
    check_lit("disabled_pos", int'(pos_w), 99);
    do_load(50, 0);
    check_lit("disabled_load", int'(pos_w), 50);
    enable = 1;

    // Reset discards a pending event.
    evt_ready = 0;
    repeat (2) tick();
    pulse(0, 1);
    check_lit("pending_evt", int'(ev_w), 1);
    rst_n = 0;
    tick();
    check_lit("rst_evt_dropped", int'(ev_w), 0);
    check_lit("rst_pos", int'(pos_w), 0);
    check_lit("rst_overrun", int'(ovr_w), 0);
    rst_n = 1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
